// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory path: access-type encodings and responder FSM states.
// Access types use the RISC-V load/store funct3 encoding.
package mem_pkg;

    localparam logic [2:0] MEM_B  = 3'b000;
    localparam logic [2:0] MEM_H  = 3'b001;
    localparam logic [2:0] MEM_W  = 3'b010;
    localparam logic [2:0] MEM_BU = 3'b100;
    localparam logic [2:0] MEM_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_state_e;

endpackage

// File: rtl/mem_lane_unit.sv
// Byte-lane steering for one 32-bit word: store byte enables and merge, load extension,
// and detection of misaligned or illegal accesses.
module mem_lane_unit
    import mem_pkg::*;
(
    input  logic [1:0]  addr,
    input  logic [2:0]  mem_type,
    input  logic        we,
    input  logic [31:0] wdata,
    input  logic [31:0] word,
    output logic [3:0]  be,
    output logic [31:0] wword,
    output logic [31:0] rdata,
    output logic        err
);

    logic [3:0]  be_raw;
    logic [31:0] wdata_rep;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Narrow store data is replicated across lanes so each lane can take its own copy.
    always_comb begin
        err       = 1'b0;
        be_raw    = 4'b0000;
        wdata_rep = wdata;
        case (mem_type)
            MEM_B: begin
                be_raw    = 4'b0001 << addr;
                wdata_rep = {4{wdata[7:0]}};
            end
            MEM_H: begin
                err       = addr[0];
                be_raw    = addr[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
            end
            MEM_W: begin
                err    = (addr != 2'b00);
                be_raw = 4'b1111;
            end
            MEM_BU:  err = we;
            MEM_HU:  err = we | addr[0];
            default: err = 1'b1;
        endcase
    end

    assign be = (we && !err) ? be_raw : 4'b0000;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign wword[8*gi +: 8] = be[gi] ? wdata_rep[8*gi +: 8] : word[8*gi +: 8];
        end
    endgenerate

    assign ld_byte = word[{addr, 3'b000} +: 8];
    assign ld_half = addr[1] ? word[31:16] : word[15:0];

    always_comb begin
        rdata = 32'h0;
        if (!we && !err) begin
            case (mem_type)
                MEM_B:   rdata = {{24{ld_byte[7]}}, ld_byte};
                MEM_BU:  rdata = {24'h0, ld_byte};
                MEM_H:   rdata = {{16{ld_half[15]}}, ld_half};
                MEM_HU:  rdata = {16'h0, ld_half};
                MEM_W:   rdata = word;
                default: rdata = 32'h0;
            endcase
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding data memory responder with a fixed request-to-response latency,
// byte/half/word loads and stores, and an error response for misaligned or illegal accesses.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic             CLK,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    input  logic [2:0]       req_type,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_rdata,
    output logic             resp_err
);

    localparam int         IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    mem_state_e         state_reg, state_next;
    logic [3:0]         cnt_reg;
    logic               we_reg;
    logic [IDX_W+1:0]   addr_reg;
    logic [WIDTH-1:0]   wdata_reg;
    logic [2:0]         type_reg;
    logic [WIDTH-1:0]   rdata_reg;
    logic               err_reg;

    logic [WIDTH-1:0]   mem [DEPTH_WORDS];
    logic [IDX_W-1:0]   word_idx;
    logic [WIDTH-1:0]   cur_word;

    logic               accept;
    logic               commit;
    logic [3:0]         lane_be;
    logic [WIDTH-1:0]   lane_wword;
    logic [WIDTH-1:0]   lane_rdata;
    logic               lane_err;
    logic               unused_addr_hi;

    // Address bits above the word index wrap around and are deliberately dropped.
    assign unused_addr_hi = ^req_addr[WIDTH-1:IDX_W+2];

    assign word_idx = addr_reg[IDX_W+1:2];
    assign cur_word = mem[word_idx];
    assign accept   = req_valid && req_ready;
    assign commit   = (state_reg == WAIT) && (cnt_reg == 4'd0);

    mem_lane_unit u_lane (
        .addr     (addr_reg[1:0]),
        .mem_type (type_reg),
        .we       (we_reg),
        .wdata    (wdata_reg),
        .word     (cur_word),
        .be       (lane_be),
        .wword    (lane_wword),
        .rdata    (lane_rdata),
        .err      (lane_err)
    );

    always_ff @(posedge CLK) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            type_reg  <= 3'b000;
            rdata_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                we_reg    <= req_we;
                addr_reg  <= req_addr[IDX_W+1:0];
                wdata_reg <= req_wdata;
                type_reg  <= req_type;
                cnt_reg   <= CNT_LOAD;
            end else if (state_reg == WAIT && cnt_reg != 4'd0) begin
                cnt_reg <= cnt_reg - 4'd1;
            end
            if (commit) begin
                rdata_reg <= lane_rdata;
                err_reg   <= lane_err;
            end else if (state_reg == RESP && resp_ready) begin
                rdata_reg <= '0;
                err_reg   <= 1'b0;
            end
        end
    end

    // Storage is never reset; a reset on the commit edge suppresses the write.
    always_ff @(posedge CLK) begin
        if (!rst && commit && (lane_be != 4'b0000)) begin
            mem[word_idx] <= lane_wword;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = WAIT;
            WAIT:    if (cnt_reg == 4'd0) state_next = RESP;
            RESP:    if (resp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (state_reg == IDLE) && !rst;
        resp_valid = (state_reg == RESP);
        resp_rdata = rdata_reg;
        resp_err   = err_reg;
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: vector table of loads/stores plus hand sequences
// for response stall, reset during WAIT, reset colliding with a request, and address aliasing.
module tb_data_mem_responder;
    import mem_pkg::*;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_type;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  typ;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    data_mem_responder #(.WIDTH(32), .DEPTH_WORDS(1024), .LATENCY(LAT)) dut (
        .CLK        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_type   (req_type),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic void add(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [2:0] typ, input logic [31:0] exp_rdata, input logic exp_err);
        vec_t v;
        v.we = we; v.addr = addr; v.wdata = wdata; v.typ = typ;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err;
        vecs.push_back(v);
    endfunction

    // Issue one request at a negedge, keep scrambled inputs asserted during WAIT/RESP,
    // measure accept-to-resp_valid latency in edges, check the response, then complete it.
    task automatic run_txn(input string name, input vec_t v);
        int n;
        int lat;
        n = 0;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        check({name, " ready"}, {31'h0, req_ready}, 32'h1);
        req_valid = 1'b1;
        req_we    = v.we;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        req_type  = v.typ;
        @(posedge clk);
        @(negedge clk);
        req_we    = ~v.we;
        req_addr  = v.addr ^ 32'h4;
        req_wdata = ~v.wdata;
        req_type  = MEM_W;
        lat = 0;
        while (!resp_valid && lat < 40) begin @(negedge clk); lat++; end
        check({name, " latency"}, lat, LAT);
        check({name, " rdata"}, resp_rdata, v.exp_rdata);
        check({name, " err"}, {31'h0, resp_err}, {31'h0, v.exp_err});
        $display("txn %s: we=%0b addr=0x%08h wdata=0x%08h type=%03b -> rdata=0x%08h err=%0b lat=%0d",
                 name, v.we, v.addr, v.wdata, v.typ, resp_rdata, resp_err, lat);
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
        req_valid  = 1'b0;
    endtask

    initial begin
        vec_t v;
        logic [31:0] held;
        int n;

        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
        req_wdata = '0; req_type = MEM_W; resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset req_ready", {31'h0, req_ready}, 32'h0);
        check("reset resp_valid", {31'h0, resp_valid}, 32'h0);
        check("reset resp_rdata", resp_rdata, 32'h0);
        check("reset resp_err", {31'h0, resp_err}, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("post-reset req_ready", {31'h0, req_ready}, 32'h1);

        add(1, 32'h10, 32'hDEADBEEF, MEM_W,  32'h0,        0);
        add(0, 32'h10, 32'h0,        MEM_W,  32'hDEADBEEF, 0);
        add(0, 32'h13, 32'h0,        MEM_B,  32'hFFFFFFDE, 0);
        add(0, 32'h13, 32'h0,        MEM_BU, 32'h000000DE, 0);
        add(0, 32'h12, 32'h0,        MEM_H,  32'hFFFFDEAD, 0);
        add(0, 32'h10, 32'h0,        MEM_HU, 32'h0000BEEF, 0);
        add(1, 32'h11, 32'h55,       MEM_B,  32'h0,        0);
        add(0, 32'h10, 32'h0,        MEM_W,  32'hDEAD55EF, 0);
        add(1, 32'h11, 32'hFFFF,     MEM_H,  32'h0,        1);
        add(0, 32'h10, 32'h0,        MEM_W,  32'hDEAD55EF, 0);
        add(0, 32'h12, 32'h0,        MEM_W,  32'h0,        1);
        add(0, 32'h10, 32'h0,        3'b011, 32'h0,        1);
        add(1, 32'h10, 32'h0,        MEM_BU, 32'h0,        1);
        add(0, 32'h11, 32'h0,        MEM_H,  32'h0,        1);
        add(0, 32'h10, 32'h0,        MEM_W,  32'hDEAD55EF, 0);
        add(1, 32'h30, 32'h11223344, MEM_W,  32'h0,        0);
        add(1, 32'h32, 32'hFFFFA5A5, MEM_H,  32'h0,        0);
        add(0, 32'h30, 32'h0,        MEM_W,  32'hA5A53344, 0);
        add(0, 32'h30, 32'h0,        MEM_B,  32'h00000044, 0);
        add(0, 32'h32, 32'h0,        MEM_B,  32'hFFFFFFA5, 0);
        add(0, 32'h32, 32'h0,        MEM_HU, 32'h0000A5A5, 0);
        add(0, 32'h31, 32'h0,        MEM_HU, 32'h0,        1);
        add(0, 32'h30, 32'h0,        3'b111, 32'h0,        1);
        add(1, 32'h20, 32'hCAFEF00D, MEM_W,  32'h0,        0);

        for (int i = 0; i < vecs.size(); i++) begin
            run_txn($sformatf("vec%0d", i), vecs[i]);
        end

        // Response held off for five cycles: everything must stay frozen.
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_type = MEM_W;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (!resp_valid && n < 40) begin @(negedge clk); n++; end
        check("stall latency", n, LAT);
        held = 32'hDEAD55EF;
        for (int c = 0; c < 5; c++) begin
            check($sformatf("stall c%0d resp_valid", c), {31'h0, resp_valid}, 32'h1);
            check($sformatf("stall c%0d rdata", c), resp_rdata, held);
            check($sformatf("stall c%0d req_ready", c), {31'h0, req_ready}, 32'h0);
            @(negedge clk);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
        check("stall release req_ready", {31'h0, req_ready}, 32'h1);
        check("stall release resp_valid", {31'h0, resp_valid}, 32'h0);
        $display("txn stall: load W 0x10 held 5 cycles then released");

        // Reset during WAIT aborts the store.
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678; req_type = MEM_W;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        for (int c = 0; c < 6; c++) begin
            if (resp_valid) n++;
            @(negedge clk);
        end
        check("abort resp_valid count", n, 0);
        $display("txn abort: store W 0x20 reset during WAIT");
        v.we = 0; v.addr = 32'h20; v.wdata = 0; v.typ = MEM_W; v.exp_rdata = 32'hCAFEF00D; v.exp_err = 0;
        run_txn("after-abort", v);

        // Request coinciding with reset must not be accepted.
        rst = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'h0; req_type = MEM_W;
        @(negedge clk);
        rst = 1'b0; req_valid = 1'b0;
        n = 0;
        for (int c = 0; c < 5; c++) begin
            if (resp_valid) n++;
            @(negedge clk);
        end
        check("rst-collide resp_valid count", n, 0);
        $display("txn rst-collide: store W 0x10 presented during reset");
        v.we = 0; v.addr = 32'h10; v.wdata = 0; v.typ = MEM_W; v.exp_rdata = 32'hDEAD55EF; v.exp_err = 0;
        run_txn("after-collide", v);

        // Upper address bits wrap: 0x1020 aliases word 0x20.
        v.we = 1; v.addr = 32'h1020; v.wdata = 32'h0BADC0DE; v.typ = MEM_W; v.exp_rdata = 0; v.exp_err = 0;
        run_txn("alias-store", v);
        v.we = 0; v.addr = 32'h20; v.wdata = 0; v.typ = MEM_W; v.exp_rdata = 32'h0BADC0DE; v.exp_err = 0;
        run_txn("alias-load", v);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter: WIDTH, 32, data and address width.
REQ-002 Parameter: DEPTH_WORDS, 1024, storage depth in 32-bit words (power of two).
REQ-003 Parameter: LATENCY, 2, cycles from request accept to first resp_valid (legal range 1..15).
REQ-004 CLK  input  1  sole clock, rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 req_valid  input  1  initiator presents a request.
REQ-007 req_ready  output  1  responder can accept a request.
REQ-008 req_we  input  1  1 = store, 0 = load.
REQ-009 req_addr  input  WIDTH  byte address.
REQ-010 req_wdata  input  WIDTH  store data, right-aligned.
REQ-011 req_type  input  3  access type, RISC-V funct3 encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-012 resp_valid  output  1  response available.
REQ-013 resp_ready  input  1  initiator accepts the response.
REQ-014 resp_rdata  output  WIDTH  load data, extended per req_type; 0 for stores and errors.
REQ-015 resp_err  output  1  request was misaligned or had an illegal type.

Function
REQ-016 The FSM SHALL have the states IDLE, WAIT and RESP; req_ready SHALL be 1 only in IDLE with rst low.
REQ-017 On req_valid&&req_ready in cycle N, the block SHALL capture we/addr/wdata/type and move to WAIT, loading a counter with LATENCY-1.
REQ-018 WAIT SHALL decrement the counter each cycle; at zero it SHALL commit the access and enter RESP, so resp_valid first rises in cycle N+LATENCY.
REQ-019 resp_valid, resp_rdata and resp_err SHALL remain stable in RESP until resp_valid&&resp_ready; the next state SHALL then be IDLE, with req_ready=1 in the following cycle.
REQ-020 Exactly one transaction SHALL be outstanding; input changes during WAIT/RESP SHALL be ignored.
REQ-021 The word index SHALL be addr[log2(DEPTH_WORDS)+1:2]; higher address bits SHALL be ignored (wrap-around).
REQ-022 The byte order SHALL be little-endian: lane k holds bits [8k+7:8k].
REQ-023 Loads SHALL be as follows: B/BU select lane addr[1:0]; H/HU select lanes addr[1]*2..+1; W selects the full word; B/H sign-extend; BU/HU zero-extend.
REQ-024 Stores SHALL be as follows: B writes lane addr[1:0] from wdata[7:0]; H writes a halfword from wdata[15:0]; W writes all lanes; other lanes SHALL be unchanged.
REQ-025 H/HU with addr[0]=1, W with addr[1:0]!=0, any type in {011,110,111}, and a store with type BU/HU SHALL set resp_err=1, perform no write and return resp_rdata=0.
REQ-026 The store write SHALL occur on the same edge that enters RESP; a load SHALL sample the array on that edge, so a load issued after a store to the same address returns the stored data.
REQ-027 The error response SHALL use the same LATENCY and handshake as a normal response.

Reset
REQ-028 While rst=1 at an edge, the state SHALL become IDLE, the counter 0, resp_valid=0, resp_rdata=0, resp_err=0 and the captured request cleared; req_ready SHALL be 0 while rst is high.
REQ-029 A reset during WAIT SHALL abort the transaction with no write; a reset during RESP SHALL drop the response; storage contents SHALL NOT be cleared by reset.
REQ-030 If rst and req_valid coincide, the request SHALL NOT be accepted.

Structure
REQ-031 A package mem_pkg SHALL hold the req_type localparams (MEM_B, MEM_H, MEM_W, MEM_BU, MEM_HU) and the FSM state enum, shared with the CPU's memory path.
REQ-032 The combinational load-extend/store-byte-mask logic SHALL be a sub-module mem_lane_unit (inputs addr[1:0], type, we, wdata, word; outputs byte-enable[3:0], merged write word, load data, err).
REQ-033 Storage SHALL be a single WIDTH x DEPTH_WORDS register array.

Verification
REQ-034 Store W addr 0x10 data 0xDEADBEEF, then load W 0x10 -> resp_rdata=0xDEADBEEF, resp_err=0, resp_valid rises exactly LATENCY cycles after each accept.
REQ-035 After REQ-034: load B 0x13 -> 0xFFFFFFDE; BU 0x13 -> 0x000000DE; H 0x12 -> 0xFFFFDEAD; HU 0x10 -> 0x0000BEEF.
REQ-036 Store B 0x11 data 0x55, then load W 0x10 -> 0xDEAD55EF; store H 0x11 -> resp_err=1, and a reload of W 0x10 is unchanged.
REQ-037 Hold resp_ready=0 for 5 cycles in RESP -> resp_valid and data stay stable and req_ready stays 0; resp_ready=1 -> req_ready=1 next cycle.
REQ-038 Store W 0x20 data 0x12345678, then assert rst during WAIT -> resp_valid never rises, and a later load W 0x20 returns the prior contents; with DEPTH_WORDS=1024, a store to 0x1020 aliases 0x20.
